// File: rtl/fd_ibuf.sv
`default_nettype none
// ============================================================================
//  Module   : fd_ibuf
//  Purpose  : Fetch-to-decode instruction buffer with valid/ready handshake
//             toward decode and occupancy-based back-pressure toward fetch.
//  Revision : 1.0  initial release
// ============================================================================
module fd_ibuf #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              f_pc,
    input  logic [31:0]              f_instr,
    input  logic                     br_en,
    output logic                     d_ready,
    output logic                     dec_valid,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_instr,
    input  logic                     dec_ready,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int                   c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]     c_FULL  = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]     c_EMPTY = '0;

    logic [31:0]        r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;

    logic               w_push;
    logic               w_pop;

    // Accept depends only on registered occupancy, never on dec_ready, so the
    // decode-to-fetch-PC path stays cut.
    assign d_ready   = !reset && (r_count != c_FULL);
    assign dec_valid = !reset && !br_en && (r_count != c_EMPTY);
    assign w_push    = d_ready && !br_en;
    assign w_pop     = dec_valid && dec_ready;

    assign dec_pc    = r_pc_mem[r_rd_ptr];
    assign dec_instr = r_instr_mem[r_rd_ptr];
    assign q_count   = r_count;

    // Entry contents carry no reset; occupancy alone says what is live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= f_pc;
            r_instr_mem[r_wr_ptr] <= f_instr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || br_en) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fd_ibuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_ibuf
//  Purpose  : Self-checking bench for fd_ibuf against a queue-based model of
//             the buffer plus a model of the fetch PC register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fd_ibuf;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        br_en;
    logic        d_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;
    logic [$clog2(DEPTH):0] q_count;

    logic [31:0] br_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_fpc;

    fd_ibuf #(.DEPTH(DEPTH)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .br_en     (br_en),
        .d_ready   (d_ready),
        .dec_valid (dec_valid),
        .dec_pc    (dec_pc),
        .dec_instr (dec_instr),
        .dec_ready (dec_ready),
        .q_count   (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {~pc[15:0], pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rst_i, input logic br_i, input logic [31:0] addr,
                        input logic dr_i);
        logic exp_dr, exp_dv, do_push, do_pop;
        @(negedge clock);
        reset     = rst_i;
        br_en     = br_i;
        br_addr   = addr;
        dec_ready = dr_i;
        f_pc      = m_fpc;
        f_instr   = instr_of(m_fpc);
        #1;
        exp_dr = !rst_i && (m_q.size() != DEPTH);
        exp_dv = !rst_i && !br_i && (m_q.size() != 0);
        chk("d_ready",   32'(d_ready),   32'(exp_dr));
        chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
        chk("q_count",   32'(q_count),   32'(m_q.size()));
        if (exp_dv) begin
            chk("dec_pc",    dec_pc,    m_q[0]);
            chk("dec_instr", dec_instr, instr_of(m_q[0]));
        end
        do_push = exp_dr && !br_i;
        do_pop  = exp_dv && dr_i;
        @(posedge clock);
        #1;
        if (rst_i) begin
            m_q.delete();
            m_fpc = 32'h0;
        end else if (br_i) begin
            m_q.delete();
            m_fpc = addr;
        end else begin
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        br_en     = 1'b0;
        br_addr   = 32'h0;
        dec_ready = 1'b0;
        f_pc      = 32'h0;
        f_instr   = instr_of(32'h0);
        m_fpc     = 32'h0;
        @(posedge clock);
        #1;
        do_reset();
        chk("rst_count", 32'(q_count), 32'd0);

        // Fill with decode stalled
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("fill_count",   32'(q_count), 32'd4);
        chk("fill_dready",  32'(d_ready), 32'd0);
        chk("fill_head_pc", dec_pc,       32'h0);

        // Drain from full: pop without push, then steady state at 3
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_count",  32'(q_count), 32'd3);
        chk("drain_dready", 32'(d_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("steady_count", 32'(q_count), 32'd3);
        end

        // Simultaneous push and pop at occupancy 2, across pointer wrap
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("pp_count", 32'(q_count), 32'd2);
        end

        // Flush on branch with 0x20, 0x24, 0x28 buffered
        step(1'b0, 1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_flush_count", 32'(q_count), 32'd3);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        chk("flush_count", 32'(q_count), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_flush_pc", dec_pc, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with 2 entries buffered
        step(1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("midrst_count", 32'(q_count), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("midrst_first_pc", dec_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Flush wins over pop on a full buffer
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        chk("brfull_count",  32'(q_count), 32'd0);
        chk("brfull_dready", 32'(d_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic r, b, d;
            r = ($urandom_range(0, 59) == 0);
            b = ($urandom_range(0, 19) == 0);
            d = (i < 400) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
            step(r, b, $urandom & 32'hFFFF_FFFC, d);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
